// File: rtl/konami_bus_pkg.sv
// Shared types for the Konami 052001-class bus decoder: regions, select bit positions,
// access FSM states.
package konami_bus_pkg;

    typedef enum logic [2:0] {
        RegProg,
        RegBank,
        RegVideo,
        RegIo,
        RegWork,
        RegNone
    } region_e;

    // Bit positions inside cs_n = {prog, bank, video, io, work}
    localparam int unsigned NumCs   = 5;
    localparam int unsigned CsProg  = 4;
    localparam int unsigned CsBank  = 3;
    localparam int unsigned CsVideo = 2;
    localparam int unsigned CsIo    = 1;
    localparam int unsigned CsWork  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StHold
    } state_e;

endpackage

// File: rtl/konami_region_decode.sv
// Combinational CPU address decode into a region and active-low select vector.
// Optional KONAMI_WOCO_EN carves a colour RAM select out of the WORK window.
module konami_region_decode
    import konami_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              woco_i,
    output region_e           region_o,
    output logic [NumCs-1:0]  sel_n_o,
    output logic              color_sel_n_o
);

    // Low address bits and woco are only consumed in some build variants
    logic unused_bits;
    assign unused_bits = ^{addr_i[12:0], woco_i};

    always_comb begin
        region_o      = RegNone;
        sel_n_o       = '1;
        color_sel_n_o = 1'b1;
        unique casez (addr_i[15:13])
            3'b1??: begin
                region_o        = RegProg;
                sel_n_o[CsProg] = 1'b0;
            end
            3'b011: begin
                region_o        = RegBank;
                sel_n_o[CsBank] = 1'b0;
            end
            3'b010: begin
                region_o         = RegVideo;
                sel_n_o[CsVideo] = 1'b0;
            end
            3'b001: begin
                region_o      = RegIo;
                sel_n_o[CsIo] = 1'b0;
            end
            3'b000: begin
                region_o = RegWork;
`ifdef KONAMI_WOCO_EN
                if (woco_i && (addr_i[12:10] == 3'b000)) begin
                    color_sel_n_o = 1'b0;
                end else begin
                    sel_n_o[CsWork] = 1'b0;
                end
`else
                sel_n_o[CsWork] = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/konami_bus_decoder_seq.sv
// Registered address decoder with ROM bank latch and per-region wait-state FSM.
// Define KONAMI_WOCO_EN to enable the colour RAM select inside the WORK window.
module konami_bus_decoder_seq
    import konami_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned BANK_W       = 5,
    parameter int unsigned WAIT_ROM     = 2,
    parameter int unsigned WAIT_OTHER   = 0,
    parameter logic [3:0]  BANK_REG_OFS = 4'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                as_n,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [7:0]          data_in,
    input  logic                init,
    input  logic                woco,
    output logic [4:0]          cs_n,
    output logic                color_cs_n,
    output logic [BANK_W+12:0]  rom_addr,
    output logic [BANK_W-1:0]   bank_q,
    output logic                cpu_wait
);

    localparam int unsigned RomW = BANK_W + 13;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [4:0]        cs_n_d;
    logic              color_cs_n_d;
    logic [RomW-1:0]   rom_addr_d;
    logic [BANK_W-1:0] bank_d;
    logic              cpu_wait_d;

    region_e           dec_region;
    logic [4:0]        dec_sel_n;
    logic              dec_color_n;
    logic [3:0]        load;
    logic              bank_wr;

    logic unused_data;
    assign unused_data = ^data_in;

    konami_region_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr_i        (addr),
        .woco_i        (woco),
        .region_o      (dec_region),
        .sel_n_o       (dec_sel_n),
        .color_sel_n_o (dec_color_n)
    );

    always_comb begin
        load    = ((dec_region == RegProg) || (dec_region == RegBank)) ?
                  4'(WAIT_ROM) : 4'(WAIT_OTHER);
        // Only the strobe-start edge can latch, so one write per strobe at most
        bank_wr = (state_q == StIdle) && !as_n && (dec_region == RegIo) && !rw &&
                  (addr[3:0] == BANK_REG_OFS);
        if (init) begin
            bank_d = '0;
        end else if (bank_wr) begin
            bank_d = data_in[BANK_W-1:0];
        end else begin
            bank_d = bank_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cs_n_d       = cs_n;
        color_cs_n_d = color_cs_n;
        rom_addr_d   = rom_addr;
        cpu_wait_d   = cpu_wait;
        unique case (state_q)
            StIdle: begin
                if (!as_n) begin
                    cs_n_d       = dec_sel_n;
                    color_cs_n_d = dec_color_n;
                    if (dec_region == RegProg) begin
                        rom_addr_d = RomW'(addr[14:0]);
                    end else if (dec_region == RegBank) begin
                        rom_addr_d = {bank_q, addr[12:0]};
                    end
                    cnt_d      = load;
                    cpu_wait_d = (load != 4'd0);
                    state_d    = (load != 4'd0) ? StAccess : StHold;
                end
            end
            StAccess: begin
                if (as_n) begin
                    cs_n_d       = '1;
                    color_cs_n_d = 1'b1;
                    cpu_wait_d   = 1'b0;
                    cnt_d        = '0;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        cpu_wait_d = 1'b0;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (as_n) begin
                    cs_n_d       = '1;
                    color_cs_n_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cs_n       <= '1;
            color_cs_n <= 1'b1;
            rom_addr   <= '0;
            bank_q     <= '0;
            cpu_wait   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_n       <= cs_n_d;
            color_cs_n <= color_cs_n_d;
            rom_addr   <= rom_addr_d;
            bank_q     <= bank_d;
            cpu_wait   <= cpu_wait_d;
        end
    end

endmodule

// File: tb/tb_konami_bus_decoder_seq.sv
// Self-checking bench for konami_bus_decoder_seq: table of full strobes plus hand sequences
// for reset, init priority, abort and asynchronous reset mid-access.
module tb_konami_bus_decoder_seq;

    logic        clk;
    logic        rst_n;
    logic        as_n;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        init;
    logic        woco;
    logic [4:0]  cs_n;
    logic        color_cs_n;
    logic [17:0] rom_addr;
    logic [4:0]  bank_q;
    logic        cpu_wait;

    int n_chk  = 0;
    int n_fail = 0;

    konami_bus_decoder_seq #(
        .ADDR_W       (16),
        .BANK_W       (5),
        .WAIT_ROM     (2),
        .WAIT_OTHER   (0),
        .BANK_REG_OFS (4'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .as_n       (as_n),
        .rw         (rw),
        .addr       (addr),
        .data_in    (data_in),
        .init       (init),
        .woco       (woco),
        .cs_n       (cs_n),
        .color_cs_n (color_cs_n),
        .rom_addr   (rom_addr),
        .bank_q     (bank_q),
        .cpu_wait   (cpu_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic        woco;
        logic [4:0]  exp_cs;
        logic        exp_color;
        logic        chk_rom;
        logic [17:0] exp_rom;
        int          exp_wait;
        logic [4:0]  exp_bank;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete strobe: assert, check selects, count wait cycles, release, check idle
    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        as_n    = 1'b0;
        addr    = v.addr;
        rw      = v.rw;
        data_in = v.data;
        woco    = v.woco;
        @(posedge clk);
        #1;
        check({v.name, ".cs_n"}, 32'(cs_n), 32'(v.exp_cs));
        check({v.name, ".color"}, 32'(color_cs_n), 32'(v.exp_color));
        if (v.chk_rom) check({v.name, ".rom"}, 32'(rom_addr), 32'(v.exp_rom));
        n = 0;
        while (cpu_wait === 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({v.name, ".wait_cycles"}, 32'(n), 32'(v.exp_wait));
        check({v.name, ".cs_hold"}, 32'(cs_n), 32'(v.exp_cs));
        @(negedge clk);
        as_n = 1'b1;
        @(posedge clk);
        #1;
        check({v.name, ".cs_release"}, 32'({cs_n, color_cs_n}), 32'(6'b111111));
        check({v.name, ".bank"}, 32'(bank_q), 32'(v.exp_bank));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{"prog_8123", 16'h8123, 1'b1, 8'h00, 1'b0, 5'b01111, 1'b1, 1'b1,
                     18'h00123, 2, 5'h00};
        vecs[1]  = '{"bankwr_15", 16'h2000, 1'b0, 8'h15, 1'b0, 5'b11101, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
        vecs[2]  = '{"bank_6abc", 16'h6ABC, 1'b1, 8'h00, 1'b0, 5'b10111, 1'b1, 1'b1,
                     18'h2AABC, 2, 5'h15};
        vecs[3]  = '{"video_4000", 16'h4000, 1'b1, 8'h00, 1'b0, 5'b11011, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
        vecs[4]  = '{"iowr_2001", 16'h2001, 1'b0, 8'h03, 1'b0, 5'b11101, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
        vecs[5]  = '{"iord_2000", 16'h2000, 1'b1, 8'h1F, 1'b0, 5'b11101, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
        vecs[6]  = '{"work_0600", 16'h0600, 1'b1, 8'h00, 1'b1, 5'b11110, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
`ifdef KONAMI_WOCO_EN
        vecs[7]  = '{"color_0200", 16'h0200, 1'b1, 8'h00, 1'b1, 5'b11111, 1'b0, 1'b0,
                     18'h0, 0, 5'h15};
`else
        vecs[7]  = '{"color_0200", 16'h0200, 1'b1, 8'h00, 1'b1, 5'b11110, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
`endif
        vecs[8]  = '{"work_0200", 16'h0200, 1'b1, 8'h00, 1'b0, 5'b11110, 1'b1, 1'b0,
                     18'h0, 0, 5'h15};
        vecs[9]  = '{"prog_ffff", 16'hFFFF, 1'b1, 8'h00, 1'b0, 5'b01111, 1'b1, 1'b1,
                     18'h07FFF, 2, 5'h15};
        vecs[10] = '{"bankwr_e9", 16'h2010, 1'b0, 8'hE9, 1'b0, 5'b11101, 1'b1, 1'b0,
                     18'h0, 0, 5'h09};
        vecs[11] = '{"bank_7fff", 16'h7FFF, 1'b1, 8'h00, 1'b0, 5'b10111, 1'b1, 1'b1,
                     18'h13FFF, 2, 5'h09};

        // Reset held with the strobe already active
        rst_n = 1'b0; as_n = 1'b0; addr = 16'h8123; rw = 1'b1;
        data_in = 8'h00; init = 1'b0; woco = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.cs_n", 32'(cs_n), 32'(5'b11111));
        check("reset.color", 32'(color_cs_n), 32'(1'b1));
        check("reset.wait", 32'(cpu_wait), 32'(1'b0));
        check("reset.bank", 32'(bank_q), 32'(5'h00));
        check("reset.rom", 32'(rom_addr), 32'(18'h0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_decode.cs_n", 32'(cs_n), 32'(5'b01111));
        check("first_decode.wait", 32'(cpu_wait), 32'(1'b1));
        n = 0;
        while (cpu_wait === 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_decode.wait_cycles", 32'(n), 32'(2));
        @(negedge clk);
        as_n = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // init wins over a simultaneous bank write, and the long strobe never relatches
        @(negedge clk);
        as_n = 1'b0; addr = 16'h2000; rw = 1'b0; data_in = 8'h07; init = 1'b1;
        @(posedge clk);
        #1;
        check("init_prio.bank", 32'(bank_q), 32'(5'h00));
        @(negedge clk);
        init = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_prio.no_relatch", 32'(bank_q), 32'(5'h00));
        @(negedge clk);
        as_n = 1'b1;
        @(posedge clk);

        // Abort on the first ACCESS cycle, then an immediate fresh access
        @(negedge clk);
        as_n = 1'b0; addr = 16'h8000; rw = 1'b1;
        @(posedge clk);
        #1;
        check("abort.start_wait", 32'(cpu_wait), 32'(1'b1));
        @(negedge clk);
        as_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort.cs_n", 32'(cs_n), 32'(5'b11111));
        check("abort.wait", 32'(cpu_wait), 32'(1'b0));
        @(negedge clk);
        as_n = 1'b0; addr = 16'h4000;
        @(posedge clk);
        #1;
        check("abort.next_cs_n", 32'(cs_n), 32'(5'b11011));
        check("abort.next_wait", 32'(cpu_wait), 32'(1'b0));
        @(negedge clk);
        as_n = 1'b1;
        @(posedge clk);

        // Asynchronous reset mid-access
        run_vec('{"bankwr_1f", 16'h2000, 1'b0, 8'h1F, 1'b0, 5'b11101, 1'b1, 1'b0,
                  18'h0, 0, 5'h1F});
        @(negedge clk);
        as_n = 1'b0; addr = 16'h6000; rw = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.pre_cs_n", 32'(cs_n), 32'(5'b10111));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.cs_n", 32'(cs_n), 32'(5'b11111));
        check("midrst.wait", 32'(cpu_wait), 32'(1'b0));
        check("midrst.bank", 32'(bank_q), 32'(5'h00));
        check("midrst.rom", 32'(rom_addr), 32'(18'h0));
        @(negedge clk);
        as_n = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
